// File: rtl/nfc_command_program_page.sv
`default_nettype none
// ============================================================================
//  Module   : nfc_command_program_page
//  Purpose  : Command-level sequencer for NAND PROGRAM PAGE. On a matching
//             request it drives the atomic command generator through
//             CMD 80h, five address cycles, a data-out burst and CMD 10h,
//             then waits for the target way's R/B# to fall and rise again.
//             The host write stream is passed to the ACG only while the
//             data-out burst is in progress.
//  Ports    : iSystemClock/iReset            clock, async active-high reset
//             iOpcode/iTargetID/iSourceID    request fields
//             iAddress/iLength/iCMDValid     request payload and valid
//             oCMDReady/oStart/oLastStep     dispatcher handshake
//             iWaySelect                     one-hot target way
//             iWrite*/oWriteReady            host write stream
//             oACG_*/iACG_*                  atomic command generator side
//  Revision : 1.0 - initial release
// ============================================================================
module nfc_command_program_page #(
    parameter int          NumberOfWays = 4,
    parameter logic [5:0]  CommandID    = 6'b000011,
    parameter logic [4:0]  TargetID     = 5'b00101,
    parameter int          RBLowTimeout = 64
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic [4:0]              iSourceID,
    input  logic [31:0]             iAddress,
    input  logic [15:0]             iLength,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    output logic                    oStart,
    output logic                    oLastStep,
    input  logic [15:0]             iWriteData,
    input  logic                    iWriteLast,
    input  logic                    iWriteValid,
    output logic                    oWriteReady,
    output logic [7:0]              oACG_Command,
    output logic [2:0]              oACG_CommandOption,
    input  logic [7:0]              iACG_Ready,
    input  logic [7:0]              iACG_LastStep,
    output logic [NumberOfWays-1:0] oACG_TargetWay,
    output logic [15:0]             oACG_NumOfData,
    output logic                    oACG_CASelect,
    output logic [39:0]             oACG_CAData,
    output logic [15:0]             oACG_WriteData,
    output logic                    oACG_WriteLast,
    output logic                    oACG_WriteValid,
    input  logic                    iACG_WriteReady,
    input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

    localparam int CntW = $clog2(RBLowTimeout + 1);
    localparam logic [CntW-1:0] cCntLast = CntW'(RBLowTimeout - 1);

    typedef enum logic [9:0] {
        S_RESET      = 10'b00_0000_0001,
        S_READY      = 10'b00_0000_0010,
        S_CMDLATCH   = 10'b00_0000_0100,
        S_CMDISSUE   = 10'b00_0000_1000,
        S_ADDRISSUE  = 10'b00_0001_0000,
        S_DATAISSUE  = 10'b00_0010_0000,
        S_CMD2ISSUE  = 10'b00_0100_0000,
        S_WAITRBLOW  = 10'b00_1000_0000,
        S_WAITRBHIGH = 10'b01_0000_0000,
        S_DONE       = 10'b10_0000_0000
    } state_t;

    state_t                  rState;
    state_t                  wNextState;
    logic                    wStart;
    logic                    wDataPhase;
    logic [23:0]             rAddress;
    logic [15:0]             rLength;
    logic [CntW-1:0]         rRBCount;
    logic [NumberOfWays-1:0] rRB;
    logic                    rWayRB;
    logic                    rCMDReady;
    logic                    rLastStep;
    logic [7:0]              rCommand;
    logic [NumberOfWays-1:0] rTargetWay;
    logic [15:0]             rNumOfData;
    logic                    rCASelect;
    logic [39:0]             rCAData;
    logic                    wUnused;

    assign wStart = (iOpcode == CommandID) & (iTargetID == TargetID) & iCMDValid;
    assign oStart = wStart;

    // Fields and primitives this block never looks at.
    assign wUnused = ^{iSourceID, iACG_Ready, iACG_LastStep[7:4],
                       iACG_LastStep[1:0], iAddress[31:24]};

    always_comb begin
        wNextState = S_READY;
        case (rState)
            S_RESET:      wNextState = S_READY;
            S_READY:      wNextState = wStart ? S_CMDLATCH : S_READY;
            S_CMDLATCH:   wNextState = S_CMDISSUE;
            S_CMDISSUE:   wNextState = iACG_LastStep[3] ? S_ADDRISSUE : S_CMDISSUE;
            S_ADDRISSUE:  wNextState = iACG_LastStep[3] ? S_DATAISSUE : S_ADDRISSUE;
            S_DATAISSUE:  wNextState = iACG_LastStep[2] ? S_CMD2ISSUE : S_DATAISSUE;
            S_CMD2ISSUE:  wNextState = iACG_LastStep[3] ? S_WAITRBLOW : S_CMD2ISSUE;
            // Leave on an observed busy, or give up after RBLowTimeout cycles
            // in case the busy pulse was too short to be seen.
            S_WAITRBLOW:  wNextState = (!rWayRB || (rRBCount == cCntLast))
                                       ? S_WAITRBHIGH : S_WAITRBLOW;
            S_WAITRBHIGH: wNextState = rWayRB ? S_DONE : S_WAITRBHIGH;
            S_DONE:       wNextState = S_READY;
            default:      wNextState = S_READY;
        endcase
    end

    // State plus registered outputs, the outputs decoded from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            rState     <= S_RESET;
            rAddress   <= '0;
            rLength    <= '0;
            rRBCount   <= '0;
            rCMDReady  <= 1'b1;
            rLastStep  <= 1'b0;
            rCommand   <= 8'h00;
            rTargetWay <= '0;
            rNumOfData <= 16'h0000;
            rCASelect  <= 1'b1;
            rCAData    <= 40'h0;
        end else begin
            rState     <= wNextState;
            rRBCount   <= (rState == S_WAITRBLOW) ? rRBCount + 1'b1 : '0;
            rCMDReady  <= 1'b0;
            rLastStep  <= 1'b0;
            rCommand   <= 8'h00;
            rNumOfData <= 16'h0000;
            rCASelect  <= 1'b1;
            rCAData    <= 40'h0;
            case (wNextState)
                S_READY: begin
                    rCMDReady  <= 1'b1;
                    rTargetWay <= iWaySelect;
                end
                S_CMDLATCH: begin
                    rTargetWay <= iWaySelect;
                    rAddress   <= iAddress[23:0];
                    rLength    <= iLength;
                end
                S_CMDISSUE: begin
                    rCommand <= 8'h08;
                    rCAData  <= 40'h80_00_00_00_00;
                end
                S_ADDRISSUE: begin
                    rCommand   <= 8'h08;
                    rCASelect  <= 1'b0;
                    rNumOfData <= 16'h0004;
                    rCAData    <= {8'h00, 8'h00, rAddress[7:0],
                                   rAddress[15:8], rAddress[23:16]};
                end
                S_DATAISSUE: begin
                    rCommand   <= 8'h04;
                    rCASelect  <= 1'b0;
                    rNumOfData <= rLength;
                end
                S_CMD2ISSUE: begin
                    rCommand <= 8'h08;
                    rCAData  <= 40'h10_00_00_00_00;
                end
                S_DONE: rLastStep <= 1'b1;
                default: ;
            endcase
        end
    end

    // Two-stage R/B# sampling of the selected way.
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            rRB    <= '0;
            rWayRB <= 1'b0;
        end else begin
            rRB    <= rTargetWay & iACG_ReadyBusy;
            rWayRB <= |rRB;
        end
    end

    assign wDataPhase = (rState == S_DATAISSUE);

    assign oCMDReady          = rCMDReady;
    assign oLastStep          = rLastStep;
    assign oACG_Command       = rCommand;
    assign oACG_CommandOption = 3'b000;
    assign oACG_TargetWay     = rTargetWay;
    assign oACG_NumOfData     = rNumOfData;
    assign oACG_CASelect      = rCASelect;
    assign oACG_CAData        = rCAData;
    assign oACG_WriteData     = iWriteData;
    assign oACG_WriteLast     = wDataPhase & iWriteLast;
    assign oACG_WriteValid    = wDataPhase & iWriteValid;
    assign oWriteReady        = wDataPhase & iACG_WriteReady;

endmodule
`default_nettype wire
